// File: rtl/spi_slave_responder.sv
// Mode-0 SPI slave with oversampled SCLK/MOSI/SS_n, a TX holding register and an RX byte strobe.
// Define SPIS_LSB_FIRST_EN to shift LSB first on both MOSI and MISO; the default is MSB first.
module spi_slave_responder #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_FILL   = '0
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              spi_SCLK,
    input  logic              spi_MOSI,
    input  logic              spi_SS_n,
    output logic              spi_MISO,
    output logic              spi_MISO_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int CNT_W    = $clog2(DATA_W) + 1;
    localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]    LAST_BIT   = CNT_W'(DATA_W - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
    logic                   sclk_prev, ss_prev;
    logic                   sclk_s, mosi_s, ss_s;
    logic                   sclk_rise, sclk_fall, ss_fall;
    logic [SETTLE_W-1:0]    settle_cnt;
    logic                   ss_armed;

    logic [1:0]        state;
    logic [CNT_W-1:0]  bitcnt;
    logic              reload;
    logic [DATA_W-1:0] tx_sr, rx_sr, rx_next, tx_shifted, load_word;
    logic [DATA_W-1:0] hold_data;
    logic              hold_full;
    logic              load_now, tx_write, miso_bit;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_MOSI};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_SS_n};
            sclk_prev <= sclk_s;
            ss_prev   <= ss_s;
        end
    end

    // The preset SS_n=1 would otherwise fake a falling edge when reset is released
    // mid-frame, so a frame may start only after a genuine high level has been seen.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            settle_cnt <= '0;
            ss_armed   <= 1'b0;
        end else if (settle_cnt != SETTLE_MAX) begin
            settle_cnt <= settle_cnt + 1'b1;
        end else if (ss_s) begin
            ss_armed <= 1'b1;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign ss_fall   = ss_prev & ~ss_s & ss_armed;

`ifdef SPIS_LSB_FIRST_EN
    assign rx_next    = {mosi_s, rx_sr[DATA_W-1:1]};
    assign tx_shifted = {1'b0, tx_sr[DATA_W-1:1]};
    assign miso_bit   = tx_sr[0];
`else
    assign rx_next    = {rx_sr[DATA_W-2:0], mosi_s};
    assign tx_shifted = {tx_sr[DATA_W-2:0], 1'b0};
    assign miso_bit   = tx_sr[DATA_W-1];
`endif

    // A load frees the holding register in the same cycle, so a concurrent write is accepted.
    assign load_now  = ~ss_s & ((state == ST_LOAD) |
                                ((state == ST_SHIFT) & sclk_fall & reload));
    assign tx_ready  = ~hold_full | load_now;
    assign tx_write  = tx_valid & tx_ready;
    assign load_word = hold_full ? hold_data : IDLE_FILL;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else begin
            if (tx_write) begin
                hold_data <= tx_data;
            end
            if (load_now) begin
                hold_full <= tx_write;
            end else if (tx_write) begin
                hold_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            bitcnt      <= '0;
            reload      <= 1'b0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= load_now & ~hold_full;
            case (state)
                ST_IDLE: begin
                    bitcnt <= '0;
                    reload <= 1'b0;
                    if (ss_fall) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (ss_s) begin
                        state <= ST_IDLE;
                    end else begin
                        tx_sr  <= load_word;
                        rx_sr  <= '0;
                        bitcnt <= '0;
                        reload <= 1'b0;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ss_s) begin
                        state  <= ST_IDLE;
                        bitcnt <= '0;
                        reload <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_sr <= rx_next;
                        if (bitcnt == LAST_BIT) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                            bitcnt   <= '0;
                            reload   <= 1'b1;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (reload) begin
                            tx_sr  <= load_word;
                            reload <= 1'b0;
                        end else begin
                            tx_sr <= tx_shifted;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (state != ST_IDLE);
    assign spi_MISO_oe = busy;
    assign spi_MISO    = busy & miso_bit;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Scoreboard bench for spi_slave_responder: a bit-banged Mode-0 master at CLOCK_50/8,
// with expected RX and MISO bytes queued at stimulus time and checked as they appear.
module tb_spi_slave_responder;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       spi_SCLK, spi_MOSI, spi_SS_n;
    logic       spi_MISO, spi_MISO_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, tx_underrun, busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int rx_count       = 0;
    int underrun_count = 0;
    int oe_cycles      = 0;
    logic [7:0] rx_q[$];
    logic [7:0] miso_q[$];

    spi_slave_responder dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .spi_SCLK    (spi_SCLK),
        .spi_MOSI    (spi_MOSI),
        .spi_SS_n    (spi_SS_n),
        .spi_MISO    (spi_MISO),
        .spi_MISO_oe (spi_MISO_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Received bytes are matched against the queue as each rx_valid strobe appears.
    always @(negedge CLOCK_50) begin
        if (rx_valid) begin
            rx_count++;
            if (rx_q.size() == 0) checkOutput("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
            else                  checkOutput("rx_byte", 32'(rx_data), 32'(rx_q.pop_front()));
        end
        if (tx_underrun) underrun_count++;
        if (spi_MISO_oe) oe_cycles++;
    end

    initial begin
        #400us;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic writeTx(input logic [7:0] d, input bit expect_out);
        int waited = 0;
        while (!tx_ready && waited < 2000) begin
            waitCycles(1);
            waited++;
        end
        if (!tx_ready) begin
            checkOutput("tx_ready_timeout", 32'(tx_ready), 32'd1);
        end else begin
            tx_data  = d;
            tx_valid = 1'b1;
            waitCycles(1);
            tx_valid = 1'b0;
            if (expect_out) miso_q.push_back(d);
        end
    endtask

    // Drives nbits SCLK pulses; MOSI changes with the falling edge, MISO is sampled at the rise.
    task automatic applyStimulus(input logic [7:0] mosi_byte, input int nbits, input bit end_frame,
                                 output logic [7:0] miso_byte);
        miso_byte = '0;
        for (int i = 0; i < nbits; i++) begin
            int idx;
`ifdef SPIS_LSB_FIRST_EN
            idx = i;
`else
            idx = 7 - i;
`endif
            spi_MOSI = mosi_byte[idx];
            waitCycles(4);
            miso_byte[idx] = spi_MISO;
            spi_SCLK = 1'b1;
            waitCycles(4);
            spi_SCLK = 1'b0;
            if (end_frame && i == nbits - 1) spi_SS_n = 1'b1;
        end
    endtask

    task automatic startFrame();
        spi_SS_n = 1'b0;
        waitCycles(8);
    endtask

    task automatic sendByte(input logic [7:0] mosi_byte, input bit last);
        logic [7:0] got;
        rx_q.push_back(mosi_byte);
        applyStimulus(mosi_byte, 8, last, got);
        if (miso_q.size() == 0) checkOutput("miso_unexpected", 32'(got), 32'hFFFF_FFFF);
        else                    checkOutput("miso_byte", 32'(got), 32'(miso_q.pop_front()));
        if (last) waitCycles(8);
    endtask

    initial begin
        int rx_before, ur_before, oe_before;
        logic [7:0] dummy;
        reset    = 1'b1;
        spi_SCLK = 1'b0;
        spi_MOSI = 1'b0;
        spi_SS_n = 1'b1;
        tx_data  = '0;
        tx_valid = 1'b0;
        waitCycles(3);
        checkOutput("rst_tx_ready", 32'(tx_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_oe", 32'(spi_MISO_oe), 32'd0);
        checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
        reset = 1'b0;
        waitCycles(10);

        $display("[TB] single byte");
        rx_before = rx_count;
        writeTx(8'hA5, 1);
        checkOutput("t1_ready_full", 32'(tx_ready), 32'd0);
        startFrame();
        checkOutput("t1_ready_after_load", 32'(tx_ready), 32'd1);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        sendByte(8'h3C, 1);
        checkOutput("t1_rx_data", 32'(rx_data), 32'h3C);
        checkOutput("t1_rx_pulses", 32'(rx_count - rx_before), 32'd1);
        checkOutput("t1_busy_end", 32'(busy), 32'd0);

        $display("[TB] burst of three");
        rx_before = rx_count;
        ur_before = underrun_count;
        writeTx(8'h11, 1);
        fork
            begin
                startFrame();
                sendByte(8'h01, 0);
                sendByte(8'h02, 0);
                sendByte(8'h03, 1);
            end
            begin
                writeTx(8'h22, 1);
                writeTx(8'h33, 1);
            end
        join
        checkOutput("t2_rx_pulses", 32'(rx_count - rx_before), 32'd3);
        checkOutput("t2_underruns", 32'(underrun_count - ur_before), 32'd0);

        $display("[TB] underrun");
        ur_before = underrun_count;
        writeTx(8'h5A, 1);
        miso_q.push_back(8'h00);
        startFrame();
        sendByte(8'h12, 0);
        sendByte(8'h34, 1);
        checkOutput("t3_underruns", 32'(underrun_count - ur_before), 32'd1);

        $display("[TB] abort");
        rx_before = rx_count;
        startFrame();
        applyStimulus(8'hFF, 5, 0, dummy);
        spi_SS_n = 1'b1;
        waitCycles(4);
        checkOutput("t4_oe_off", 32'(spi_MISO_oe), 32'd0);
        waitCycles(8);
        checkOutput("t4_no_rx", 32'(rx_count - rx_before), 32'd0);
        miso_q.push_back(8'h00);
        startFrame();
        sendByte(8'hC3, 1);
        checkOutput("t4_rx_data", 32'(rx_data), 32'hC3);

        $display("[TB] SCLK while deselected");
        rx_before = rx_count;
        oe_before = oe_cycles;
        for (int e = 0; e < 16; e++) begin
            spi_SCLK = ~spi_SCLK;
            spi_MOSI = e[1];
            waitCycles(4);
        end
        waitCycles(8);
        checkOutput("t6_no_rx", 32'(rx_count - rx_before), 32'd0);
        checkOutput("t6_oe_cycles", 32'(oe_cycles - oe_before), 32'd0);

        $display("[TB] reset mid-frame");
        writeTx(8'h77, 0);
        startFrame();
        writeTx(8'h88, 0);
        checkOutput("t5_ready_full", 32'(tx_ready), 32'd0);
        applyStimulus(8'hE1, 3, 0, dummy);
        reset = 1'b1;
        #1;
        checkOutput("t5_rst_miso", 32'(spi_MISO), 32'd0);
        checkOutput("t5_rst_oe", 32'(spi_MISO_oe), 32'd0);
        checkOutput("t5_rst_ready", 32'(tx_ready), 32'd1);
        checkOutput("t5_rst_rx_data", 32'(rx_data), 32'd0);
        checkOutput("t5_rst_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("t5_rst_underrun", 32'(tx_underrun), 32'd0);
        checkOutput("t5_rst_busy", 32'(busy), 32'd0);
        waitCycles(3);
        reset = 1'b0;
        rx_before = rx_count;
        oe_before = oe_cycles;
        applyStimulus(8'h00, 5, 1, dummy);
        waitCycles(10);
        checkOutput("t5_no_rx", 32'(rx_count - rx_before), 32'd0);
        checkOutput("t5_no_oe", 32'(oe_cycles - oe_before), 32'd0);
        miso_q.push_back(8'h00);
        startFrame();
        sendByte(8'h96, 1);
        checkOutput("t5_fresh_rx", 32'(rx_data), 32'h96);

        $display("[TB] bit stream 1,0,0,0,0,0,0,0");
        miso_q.push_back(8'h00);
        startFrame();
`ifdef SPIS_LSB_FIRST_EN
        sendByte(8'h01, 1);
        checkOutput("t7_lsb_rx", 32'(rx_data), 32'h01);
`else
        sendByte(8'h80, 1);
        checkOutput("t7_msb_rx", 32'(rx_data), 32'h80);
`endif

        waitCycles(8);
        checkOutput("rx_pending", 32'(rx_q.size()), 32'd0);
        checkOutput("miso_pending", 32'(miso_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
